// File: rtl/interrupt_dispatch.sv
// rtl/interrupt_dispatch.sv - priority interrupt selector with request/ack handshake, source clear strobe and handler residency tracking
module interrupt_dispatch #(
  parameter int                    NUM_SRC    = 16,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] VEC_BASE   = 16'hF000,
  parameter int                    VEC_SHIFT  = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [15:0]           Interrupt_Register,
  input  logic                  IMASK_WR,
  input  logic [15:0]           IMASK_DATA,
  input  logic                  IE_SET,
  input  logic                  IE_CLR,
  input  logic                  INT_ACK,
  input  logic                  RETI,
  output logic                  INT_REQ,
  output logic [ADDR_WIDTH-1:0] INT_VECTOR,
  output logic [3:0]            ACTIVE_ID,
  output logic [3:0]            IR_CLR_SELECT,
  output logic                  IR_CLR_EN,
  output logic [15:0]           IMASK,
  output logic                  IE,
  output logic                  BUSY
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_CLEAR   = 2'd2,
    S_SERVICE = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_imask;
  logic        r_ie;
  logic        r_saved_ie;
  logic [3:0]  r_active_id;
  logic        r_int_req;
  logic        r_ir_clr_en;
  logic [3:0]  r_ir_clr_sel;
  logic        r_busy;

  logic [15:0] w_eligible;
  logic        w_any;
  logic [3:0]  w_win_id;
  logic        w_ie_upd;
  logic        w_sav_upd;

  assign w_eligible = Interrupt_Register & r_imask;
  assign w_any      = |w_eligible;

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    w_win_id = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_win_id = 4'(i);
    end
  end

  // Clear beats set when both enable controls arrive together.
  assign w_ie_upd  = IE_CLR ? 1'b0 : (IE_SET ? 1'b1 : r_ie);
  assign w_sav_upd = IE_CLR ? 1'b0 : (IE_SET ? 1'b1 : r_saved_ie);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state      <= S_IDLE;
      r_imask      <= 16'd0;
      r_ie         <= 1'b0;
      r_saved_ie   <= 1'b0;
      r_active_id  <= 4'd0;
      r_int_req    <= 1'b0;
      r_ir_clr_en  <= 1'b0;
      r_ir_clr_sel <= 4'd0;
      r_busy       <= 1'b0;
    end else begin
      if (IMASK_WR) r_imask <= IMASK_DATA;
      // While a handler runs, enable writes land in the saved copy.
      if (r_state != S_SERVICE) r_ie <= w_ie_upd;
      else                      r_saved_ie <= w_sav_upd;

      case (r_state)
        S_IDLE: begin
          if (r_ie && w_any) begin
            r_active_id <= w_win_id;
            r_int_req   <= 1'b1;
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (INT_ACK) begin
            r_int_req    <= 1'b0;
            r_ir_clr_en  <= 1'b1;
            r_ir_clr_sel <= r_active_id;
            r_state      <= S_CLEAR;
          end else if (!w_eligible[r_active_id] || !r_ie || IE_CLR) begin
            r_int_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_CLEAR: begin
          r_ir_clr_en <= 1'b0;
          r_saved_ie  <= w_ie_upd;
          r_ie        <= 1'b0;
          r_busy      <= 1'b1;
          r_state     <= S_SERVICE;
        end
        S_SERVICE: begin
          if (RETI) begin
            r_ie    <= w_sav_upd;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign INT_VECTOR    = VEC_BASE + (ADDR_WIDTH'(r_active_id) << VEC_SHIFT);
  assign INT_REQ       = r_int_req;
  assign ACTIVE_ID     = r_active_id;
  assign IR_CLR_SELECT = r_ir_clr_sel;
  assign IR_CLR_EN     = r_ir_clr_en;
  assign IMASK         = r_imask;
  assign IE            = r_ie;
  assign BUSY          = r_busy;

endmodule

// File: tb/tb_interrupt_dispatch.sv
// tb/tb_interrupt_dispatch.sv - directed and randomized checks of interrupt_dispatch against a behavioural model
module tb_interrupt_dispatch;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] Interrupt_Register;
  logic        IMASK_WR;
  logic [15:0] IMASK_DATA;
  logic        IE_SET;
  logic        IE_CLR;
  logic        INT_ACK;
  logic        RETI;
  logic        INT_REQ;
  logic [15:0] INT_VECTOR;
  logic [3:0]  ACTIVE_ID;
  logic [3:0]  IR_CLR_SELECT;
  logic        IR_CLR_EN;
  logic [15:0] IMASK;
  logic        IE;
  logic        BUSY;

  interrupt_dispatch dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .Interrupt_Register (Interrupt_Register),
    .IMASK_WR           (IMASK_WR),
    .IMASK_DATA         (IMASK_DATA),
    .IE_SET             (IE_SET),
    .IE_CLR             (IE_CLR),
    .INT_ACK            (INT_ACK),
    .RETI               (RETI),
    .INT_REQ            (INT_REQ),
    .INT_VECTOR         (INT_VECTOR),
    .ACTIVE_ID          (ACTIVE_ID),
    .IR_CLR_SELECT      (IR_CLR_SELECT),
    .IR_CLR_EN          (IR_CLR_EN),
    .IMASK              (IMASK),
    .IE                 (IE),
    .BUSY               (BUSY)
  );

  always #5 CLK = ~CLK;

  localparam int WAITING = 0, ASKING = 1, CLEARING = 2, IN_HANDLER = 3;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          ph;
  logic [15:0] m_mask;
  logic        m_ie, m_saved, m_req, m_clr, m_busy;
  int          m_id, m_clr_sel;

  function automatic int lowest_set(input logic [15:0] v);
    logic [15:0] iso;
    iso = v & (~v + 16'd1);
    return $clog2(iso);
  endfunction

  task automatic model_reset();
    ph = WAITING; m_mask = 16'd0; m_ie = 0; m_saved = 0;
    m_req = 0; m_clr = 0; m_busy = 0; m_id = 0; m_clr_sel = 0;
  endtask

  task automatic model_clock();
    logic [15:0] elig;
    logic        ie_n, sav_n;
    elig  = Interrupt_Register & m_mask;
    ie_n  = m_ie;
    sav_n = m_saved;
    if (ph == IN_HANDLER) sav_n = IE_CLR ? 1'b0 : (IE_SET ? 1'b1 : sav_n);
    else                  ie_n  = IE_CLR ? 1'b0 : (IE_SET ? 1'b1 : ie_n);
    if (IMASK_WR) m_mask = IMASK_DATA;
    if (ph == WAITING) begin
      if (m_ie && elig != 0) begin m_id = lowest_set(elig); m_req = 1; ph = ASKING; end
    end else if (ph == ASKING) begin
      if (INT_ACK) begin m_req = 0; m_clr = 1; m_clr_sel = m_id; ph = CLEARING; end
      else if (!elig[m_id] || !m_ie || IE_CLR) begin m_req = 0; ph = WAITING; end
    end else if (ph == CLEARING) begin
      m_clr = 0; sav_n = ie_n; ie_n = 0; m_busy = 1; ph = IN_HANDLER;
    end else begin
      if (RETI) begin ie_n = sav_n; m_busy = 0; ph = WAITING; end
    end
    m_ie = ie_n;
    m_saved = sav_n;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("int_req", INT_REQ, m_req);
    chk("active_id", ACTIVE_ID, m_id);
    chk("int_vector", INT_VECTOR, 32'hF000 + m_id * 4);
    chk("ir_clr_en", IR_CLR_EN, m_clr);
    chk("ir_clr_select", IR_CLR_SELECT, m_clr_sel);
    chk("imask", IMASK, m_mask);
    chk("ie", IE, m_ie);
    chk("busy", BUSY, m_busy);
  endtask

  task automatic step();
    @(posedge CLK);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    IMASK_WR = 0; IE_SET = 0; IE_CLR = 0; INT_ACK = 0; RETI = 0;
  endtask

  task automatic async_reset();
    #3 RESET = 1'b0;
    #1 model_reset();
    check_all();
    chk("reset_clr_en", IR_CLR_EN, 0);
    chk("reset_int_req", INT_REQ, 0);
    chk("reset_imask", IMASK, 0);
    #2 RESET = 1'b1;
  endtask

  function automatic logic [15:0] rand_pending();
    if ($urandom_range(0, 4) == 0) return 16'd0;
    return 16'($urandom) & 16'($urandom) & 16'($urandom);
  endfunction

  initial begin
    RESET = 1'b0; Interrupt_Register = 16'd0; IMASK_DATA = 16'd0;
    idle_inputs();
    model_reset();
    #12;
    check_all();
    RESET = 1'b1;

    // Basic request for source 5
    IMASK_WR = 1; IMASK_DATA = 16'hFFFF; IE_SET = 1;
    step();
    idle_inputs(); Interrupt_Register = 16'h0020;
    chk("req_before_latency", INT_REQ, 0);
    step();
    chk("tp1_req", INT_REQ, 1);
    chk("tp1_id", ACTIVE_ID, 5);
    chk("tp1_vec", INT_VECTOR, 16'hF014);
    Interrupt_Register = 16'h0000;
    step();

    // Priority, ack, clear strobe, service
    Interrupt_Register = 16'h8009;
    step();
    chk("tp2_id", ACTIVE_ID, 0);
    chk("tp2_vec", INT_VECTOR, 16'hF000);
    INT_ACK = 1;
    step();
    chk("tp2_clr_en", IR_CLR_EN, 1);
    chk("tp2_clr_sel", IR_CLR_SELECT, 0);
    INT_ACK = 0; Interrupt_Register = 16'h0004;
    step();
    chk("tp2_busy", BUSY, 1);
    chk("tp2_ie", IE, 0);
    chk("tp2_clr_off", IR_CLR_EN, 0);
    step();
    chk("svc_no_req", INT_REQ, 0);
    RETI = 1;
    step();
    chk("tp4_ie", IE, 1);
    chk("tp4_busy", BUSY, 0);
    RETI = 0;
    step();
    chk("tp4_req", INT_REQ, 1);
    chk("tp4_id", ACTIVE_ID, 2);

    // Withdraw when pending bit drops
    Interrupt_Register = 16'h0008;
    step();
    chk("wd_req_off", INT_REQ, 0);
    step();
    chk("tp3_id", ACTIVE_ID, 3);
    Interrupt_Register = 16'h0000;
    step();
    chk("tp3_req", INT_REQ, 0);
    chk("tp3_no_clr", IR_CLR_EN, 0);

    // Simultaneous set/clear in REQ
    Interrupt_Register = 16'h0010;
    step();
    IE_SET = 1; IE_CLR = 1;
    step();
    chk("tp5_ie", IE, 0);
    chk("tp5_req", INT_REQ, 0);
    IE_CLR = 0;
    step();
    IE_SET = 0;
    step();
    IE_SET = 1; IE_CLR = 1; INT_ACK = 1;
    step();
    chk("tp5_ack_clr", IR_CLR_EN, 1);
    chk("tp5_ack_sel", IR_CLR_SELECT, 4);
    idle_inputs();
    step();
    RETI = 1;
    step();
    RETI = 0; IE_SET = 1; Interrupt_Register = 16'h0001;
    step();
    IE_SET = 0;
    step();
    INT_ACK = 1;
    step();
    INT_ACK = 0;
    chk("tp6_in_clear", IR_CLR_EN, 1);
    async_reset();
    chk("tp6_busy", BUSY, 0);
    chk("tp6_ie", IE, 0);
    step();

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) Interrupt_Register = rand_pending();
      IMASK_WR   = ($urandom_range(0, 19) == 0);
      IMASK_DATA = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
      INT_ACK    = (ph == ASKING) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      RETI       = (ph == IN_HANDLER) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
      IE_SET     = ($urandom_range(0, 4) == 0);
      IE_CLR     = ($urandom_range(0, 11) == 0);
      if (ph == CLEARING || (ph == IN_HANDLER && RETI)) begin IE_SET = 0; IE_CLR = 0; end
      step();
      if (c % 1000 == 500) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/interrupt_dispatch.md
Name: interrupt_dispatch

Overview:
- Reads the pending-interrupt vector produced by interrupt_control and selects the highest-priority unmasked source.
- Handshakes with the main control FSM to take the interrupt at an instruction boundary.
- Returns a clear request, IR_CLR_SELECT plus a strobe, to interrupt_control and supplies the handler address.
- Tracks handler residency until RETI; no nesting.

Parameters:
- NUM_SRC, 16, number of pending bits in Interrupt_Register; fixed at 16 so that the IDs fit in 4 bits.
- ADDR_WIDTH, 16, width of INT_VECTOR.
- VEC_BASE, 16'hF000, handler table base address.
- VEC_SHIFT, 2, log2 of the per-source handler slot size in words.

Ports:
- CLK  in  1  rising-edge clock.
- RESET  in  1  asynchronous reset, active-low (0 = reset).
- Interrupt_Register  in  16  pending bits from interrupt_control; bit 0 = highest priority.
- IMASK_WR  in  1  load IMASK from IMASK_DATA this cycle.
- IMASK_DATA  in  16  new mask value; 1 = source enabled.
- IE_SET  in  1  set the global enable.
- IE_CLR  in  1  clear the global enable.
- INT_ACK  in  1  control FSM has saved the PC (EPCWrite done) and is jumping to INT_VECTOR.
- RETI  in  1  control FSM executing return-from-interrupt.
- INT_REQ  out  1  interrupt request to the control FSM.
- INT_VECTOR  out  ADDR_WIDTH  handler address for ACTIVE_ID.
- ACTIVE_ID  out  4  latched winning source.
- IR_CLR_SELECT  out  4  source to clear in interrupt_control.
- IR_CLR_EN  out  1  one-cycle clear strobe.
- IMASK  out  16  current mask register.
- IE  out  1  current global enable.
- BUSY  out  1  handler in progress.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE; IMASK=0; IE=0; saved_ie=0; ACTIVE_ID=0; INT_REQ=0; IR_CLR_EN=0; IR_CLR_SELECT=0; BUSY=0. All outputs are registered except INT_VECTOR.
- INT_VECTOR is combinational: VEC_BASE + (ACTIVE_ID << VEC_SHIFT), truncated to ADDR_WIDTH. It is only meaningful when INT_REQ or BUSY is 1.
- eligible = Interrupt_Register & IMASK, evaluated combinationally each cycle. The winner is the lowest set index.
- IMASK_WR takes effect at the clock edge in any state. The new mask is used from the next cycle.
- IE_SET/IE_CLR in IDLE/REQ/CLEAR update IE. If both are asserted, IE_CLR wins. In SERVICE they update saved_ie instead, and IE stays 0.
- State machine IDLE -> REQ -> CLEAR -> SERVICE -> IDLE:
  - IDLE: if IE=1 and eligible!=0, latch the winner into ACTIVE_ID, set INT_REQ=1, go to REQ. INT_REQ rises on the edge after the pending bit is visible (1-cycle latency).
  - REQ: INT_REQ held, ACTIVE_ID frozen; later higher-priority arrivals do not preempt.
    - If INT_ACK=1: go to CLEAR, INT_REQ=0.
    - Else if eligible[ACTIVE_ID]=0 (masked or cleared) or IE=0 or IE_CLR=1: withdraw; INT_REQ=0, go to IDLE.
    - INT_ACK wins over a simultaneous withdraw condition.
  - CLEAR (1 cycle): IR_CLR_EN=1 and IR_CLR_SELECT=ACTIVE_ID for exactly this cycle. On exit: saved_ie=IE, IE=0, BUSY=1, go to SERVICE.
  - SERVICE: BUSY=1. New pending bits are retained by interrupt_control but not requested. On RETI: IE=saved_ie, BUSY=0, go to IDLE. Re-arbitration happens the next cycle, so a still-pending source raises INT_REQ 1 cycle after RETI.
- IR_CLR_EN is 0 and IR_CLR_SELECT holds its last value outside CLEAR.
- INT_ACK outside REQ and RETI outside SERVICE are ignored.
- RESET asserted mid-operation (any state) returns to the reset values immediately. No clear strobe is issued.

Test Plan:
- Reset, IMASK_WR with 16'hFFFF, IE_SET, then Interrupt_Register=16'h0020 -> INT_REQ=1 one cycle later, ACTIVE_ID=5, INT_VECTOR=16'hF014.
- Interrupt_Register=16'h8009, IE=1, mask all ones -> ACTIVE_ID=0, INT_VECTOR=16'hF000. After INT_ACK: one-cycle IR_CLR_EN with IR_CLR_SELECT=0, then BUSY=1 and IE=0.
- In REQ for source 3, Interrupt_Register bit 3 dropped with no ACK -> INT_REQ falls next edge, state IDLE, no IR_CLR_EN pulse.
- In SERVICE, Interrupt_Register=16'h0004, then RETI -> IE=1, BUSY=0, and INT_REQ=1 with ACTIVE_ID=2 one cycle after RETI.
- In REQ, IE_SET and IE_CLR asserted together with INT_ACK=0 -> IE=0 and the request is withdrawn. Repeat with INT_ACK=1 -> goes to CLEAR.
- RESET driven low asynchronously during CLEAR -> IR_CLR_EN, INT_REQ, BUSY, IE, and IMASK all read 0 before the next CLK edge.
